// File: rtl/rom_load_sequencer_pkg.sv
// Shared types and defaults for the ROM download sequencer.
package rom_load_sequencer_pkg;

   localparam int unsigned DEF_ROM_SIZE = 32'h0001_0000;

   typedef enum logic [2:0] {
      ST_WAIT_DL = 3'd0,
      ST_LOAD    = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RUN     = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic [16:0] addr;
      logic [7:0]  data;
   } fifo_entry_t;

endpackage

// File: rtl/rom_load_sequencer_if.sv
// Download bus: hps_io ioctl side plus the core ROM write port.
interface rom_load_sequencer_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait, dn_addr, dn_data, dn_wr
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait, dn_addr, dn_data, dn_wr
   );
endinterface

// File: rtl/rom_load_sequencer_dl_fifo.sv
// Small synchronous byte FIFO between the ioctl strobe and the paced ROM writer.
module dl_fifo
   import rom_load_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_flush,
   input  logic          i_push,
   input  fifo_entry_t   i_data,
   input  logic          i_pop,
   output fifo_entry_t   o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   fifo_entry_t   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(FIFO_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset because the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
   always_ff @(posedge i_clk) begin
      if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

endmodule

// File: rtl/rom_load_sequencer.sv
// Paces HPS ROM download bytes into the core ROM port and owns the core reset.
//
// state   | meaning
// --------+------------------------------------------------
// WAIT_DL | out of reset, no ROM loaded yet
// LOAD    | download window open, bytes accepted
// DRAIN   | window closed, FIFO still emptying
// HOLD    | settle counter running, core held in reset
// RUN     | core released
module rom_load_sequencer
   import rom_load_sequencer_pkg::*;
#(
   parameter int unsigned ROM_SIZE   = DEF_ROM_SIZE,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WR_GAP     = 2,
   parameter int unsigned RESET_HOLD = 1024
) (
   input  logic                 i_clk_sys,
   input  logic                 i_reset,
   rom_load_sequencer_if.slave  bus,
   input  logic                 i_ext_reset,
   output logic                 o_core_reset,
   output logic                 o_busy,
   output logic                 o_oor,
   output logic                 o_ovf
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned GW = $clog2(WR_GAP + 1);
   localparam int unsigned HW = $clog2(RESET_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

   seq_state_e    r_state;
   seq_state_e    w_state_nxt;
   logic [HW-1:0] r_hold;
   logic [HW-1:0] w_hold_nxt;
   logic [GW-1:0] r_gap;
   logic          r_core_reset;
   logic          r_busy;
   logic          w_core_reset_nxt;
   logic          w_busy_nxt;
   logic          r_oor;
   logic          r_ovf;
   logic          r_wait;
   logic [16:0]   r_dn_addr;
   logic [7:0]    r_dn_data;
   logic          r_dn_wr;

   logic          w_in_range;
   logic          w_in_load;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_nxt;
   fifo_entry_t   w_fifo_in;
   fifo_entry_t   w_fifo_head;
   logic          w_enter_load;

   assign w_in_range   = (32'(bus.ioctl_addr) < ROM_SIZE);
   assign w_in_load    = (r_state == ST_LOAD);
   assign w_push       = w_in_load && bus.ioctl_wr && w_in_range && !w_full;
   assign w_pop        = !w_empty && (r_gap == '0);
   assign w_count_nxt  = w_count + CW'(w_push) - CW'(w_pop);
   assign w_enter_load = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
   assign w_fifo_in    = '{addr: bus.ioctl_addr[16:0], data: bus.ioctl_dout};

   dl_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk_sys),
      .i_flush (i_reset),
      .i_push  (w_push),
      .i_data  (w_fifo_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // State register; core_reset and busy are registered from the next state.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state      <= ST_WAIT_DL;
         r_hold       <= '0;
         r_core_reset <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold       <= w_hold_nxt;
         r_core_reset <= w_core_reset_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Next-state and settle-counter decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      unique case (r_state)
         ST_WAIT_DL: begin
            if (bus.ioctl_download) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!bus.ioctl_download) begin
               if (w_empty) begin
                  w_state_nxt = ST_HOLD;
                  w_hold_nxt  = '0;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Wait for the last strobe to retire so HOLD starts after the final write.
            if (w_empty && !r_dn_wr) begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = '0;
            end
         end
         ST_HOLD: begin
            if (bus.ioctl_download) begin
               w_state_nxt = ST_LOAD;
            end else if (i_ext_reset) begin
               w_hold_nxt = '0;
            end else if (r_hold == HOLD_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_hold_nxt = r_hold + HW'(1);
            end
         end
         ST_RUN: begin
            if (bus.ioctl_download) begin
               w_state_nxt = ST_LOAD;
            end else if (i_ext_reset) begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ST_WAIT_DL;
         end
      endcase
   end

   // Output decode of the upcoming state.
   always_comb begin
      w_core_reset_nxt = (w_state_nxt != ST_RUN);
      w_busy_nxt       = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_DRAIN) ||
                         (w_state_nxt == ST_HOLD);
   end

   // Paced ROM writer: one strobe per pop, then WR_GAP-1 idle cycles.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_gap     <= '0;
         r_dn_addr <= '0;
         r_dn_data <= '0;
         r_dn_wr   <= 1'b0;
      end else if (w_pop) begin
         r_gap     <= GW'(WR_GAP - 1);
         r_dn_addr <= w_fifo_head.addr;
         r_dn_data <= w_fifo_head.data;
         r_dn_wr   <= 1'b1;
      end else begin
         r_dn_wr <= 1'b0;
         if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
         end
      end
   end

   // Sticky error flags, cleared each time a new download window opens.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_oor <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_enter_load) begin
         r_oor <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_in_load && bus.ioctl_wr) begin
         if (!w_in_range) begin
            r_oor <= 1'b1;
         end else if (w_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Backpressure one entry early so a strobe already in flight still fits.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_wait <= 1'b0;
      end else begin
         r_wait <= (w_count_nxt >= CW'(FIFO_DEPTH - 1));
      end
   end

   assign bus.ioctl_wait = r_wait;
   assign bus.dn_addr    = r_dn_addr;
   assign bus.dn_data    = r_dn_data;
   assign bus.dn_wr      = r_dn_wr;
   assign o_core_reset   = r_core_reset;
   assign o_busy         = r_busy;
   assign o_oor          = r_oor;
   assign o_ovf          = r_ovf;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: cycle model of the download rules plus directed checks.
module tb_rom_load_sequencer;

   localparam int unsigned ROM_SIZE   = 32'h0001_0000;
   localparam int unsigned DEPTH      = 4;
   localparam int unsigned WR_GAP     = 2;
   localparam int unsigned RESET_HOLD = 1024;

   localparam int M_WAIT  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_DRAIN = 2;
   localparam int M_HOLD  = 3;
   localparam int M_RUN   = 4;

   logic clk = 1'b0;
   logic rst;
   logic ext;
   logic core_reset, busy, oor, ovf;

   rom_load_sequencer_if bus ();

   rom_load_sequencer #(
      .ROM_SIZE   (ROM_SIZE),
      .FIFO_DEPTH (DEPTH),
      .WR_GAP     (WR_GAP),
      .RESET_HOLD (RESET_HOLD)
   ) dut (
      .i_clk_sys    (clk),
      .i_reset      (rst),
      .bus          (bus),
      .i_ext_reset  (ext),
      .o_core_reset (core_reset),
      .o_busy       (busy),
      .o_oor        (oor),
      .o_ovf        (ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [24:0] mq[$];
   int          m_state, m_gap, m_hold;
   logic [16:0] m_dn_addr;
   logic [7:0]  m_dn_data;
   bit          m_dn_wr, m_oor, m_ovf, m_wait, m_core_reset, m_busy;

   always @(posedge clk) begin : model
      bit          was_empty, was_full, pushed, prev_wr;
      logic [24:0] e;
      if (rst) begin
         mq.delete();
         m_state = M_WAIT; m_gap = 0; m_hold = 0;
         m_dn_addr = '0; m_dn_data = '0; m_dn_wr = 0; m_oor = 0; m_ovf = 0;
      end else begin
         was_empty = (mq.size() == 0);
         was_full  = (mq.size() == DEPTH);
         prev_wr   = m_dn_wr;
         pushed    = 0;
         if (m_state == M_LOAD && bus.ioctl_wr) begin
            if (32'(bus.ioctl_addr) >= ROM_SIZE) m_oor = 1;
            else if (was_full) m_ovf = 1;
            else pushed = 1;
         end
         if (!was_empty && m_gap == 0) begin
            e = mq.pop_front();
            m_dn_addr = e[24:8];
            m_dn_data = e[7:0];
            m_dn_wr   = 1;
            m_gap     = WR_GAP - 1;
         end else begin
            m_dn_wr = 0;
            if (m_gap > 0) m_gap--;
         end
         if (pushed) mq.push_back({bus.ioctl_addr[16:0], bus.ioctl_dout});
         case (m_state)
            M_WAIT: if (bus.ioctl_download) begin m_state = M_LOAD; m_oor = 0; m_ovf = 0; end
            M_LOAD: if (!bus.ioctl_download) begin
               if (was_empty) begin m_state = M_HOLD; m_hold = 0; end
               else m_state = M_DRAIN;
            end
            M_DRAIN: if (was_empty && !prev_wr) begin m_state = M_HOLD; m_hold = 0; end
            M_HOLD: begin
               if (bus.ioctl_download) begin m_state = M_LOAD; m_oor = 0; m_ovf = 0; end
               else if (ext) m_hold = 0;
               else if (m_hold == RESET_HOLD - 1) m_state = M_RUN;
               else m_hold++;
            end
            default: begin
               if (bus.ioctl_download) begin m_state = M_LOAD; m_oor = 0; m_ovf = 0; end
               else if (ext) begin m_state = M_HOLD; m_hold = 0; end
            end
         endcase
      end
      m_wait       = (mq.size() >= DEPTH - 1);
      m_core_reset = (m_state != M_RUN);
      m_busy       = (m_state == M_LOAD) || (m_state == M_DRAIN) || (m_state == M_HOLD);
   end

   // ---------------- per-cycle compare ----------------
   logic [24:0] got[$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("core_reset", 32'(core_reset), 32'(m_core_reset));
         chk("busy",       32'(busy),       32'(m_busy));
         chk("dn_wr",      32'(bus.dn_wr),  32'(m_dn_wr));
         chk("dn_addr",    32'(bus.dn_addr), 32'(m_dn_addr));
         chk("dn_data",    32'(bus.dn_data), 32'(m_dn_data));
         chk("ioctl_wait", 32'(bus.ioctl_wait), 32'(m_wait));
         chk("oor",        32'(oor),        32'(m_oor));
         chk("ovf",        32'(ovf),        32'(m_ovf));
         if (bus.dn_wr) got.push_back({bus.dn_addr, bus.dn_data});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges from now until core_reset is seen low, counting dn_wr pulses on the way.
   task automatic measure_fall(output int n, output int pulses);
      n = 0;
      pulses = 0;
      while (n < 1500) begin
         step();
         n++;
         if (bus.dn_wr) pulses++;
         if (!core_reset) break;
      end
   endtask

   logic [7:0] bdata [8] = '{8'h11, 8'h22, 8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h70, 8'h81};
   int  n_edges, n_pulses, i, guard;
   bit  saw_wait;

   initial begin
      rst = 1; ext = 0;
      bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk_en = 1;

      // idle after reset: stays in WAIT_DL
      repeat (50) step();
      chk("idle_core_reset", 32'(core_reset), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_dn_wr", 32'(bus.dn_wr), 32'd0);
      chk("idle_dn_addr", 32'(bus.dn_addr), 32'd0);

      // single byte latency
      bus.ioctl_download = 1;
      step();
      bus.ioctl_wr = 1; bus.ioctl_addr = 25'h00010; bus.ioctl_dout = 8'hA5;
      step();
      bus.ioctl_wr = 0;
      chk("lat_edgeN_dn_wr", 32'(bus.dn_wr), 32'd0);
      step();
      chk("lat_edgeN1_dn_wr", 32'(bus.dn_wr), 32'd1);
      chk("lat_dn_addr", 32'(bus.dn_addr), 32'h0010);
      chk("lat_dn_data", 32'(bus.dn_data), 32'hA5);
      step();
      chk("lat_pulse_width", 32'(bus.dn_wr), 32'd0);

      // out-of-range address
      got.delete();
      bus.ioctl_wr = 1; bus.ioctl_addr = 25'h10000; bus.ioctl_dout = 8'h55;
      step();
      bus.ioctl_wr = 0;
      repeat (4) step();
      chk("oor_set", 32'(oor), 32'd1);
      chk("oor_no_write", 32'(got.size()), 32'd0);

      // window closes with empty FIFO: HOLD next edge, release 1024 later
      bus.ioctl_download = 0;
      measure_fall(n_edges, n_pulses);
      chk("hold_after_load_edges", 32'(n_edges), 32'd1025);
      chk("oor_sticky", 32'(oor), 32'd1);

      // 8-byte burst honoring wait, then close window with entries queued
      got.delete();
      bus.ioctl_download = 1;
      step();
      chk("oor_cleared_on_load", 32'(oor), 32'd0);
      i = 0; saw_wait = 0; guard = 0;
      while (i < 8 && guard < 100) begin
         if (!bus.ioctl_wait) begin
            bus.ioctl_wr = 1; bus.ioctl_addr = 25'(32'h100 + i); bus.ioctl_dout = bdata[i];
            i++;
         end else begin
            bus.ioctl_wr = 0;
         end
         step();
         guard++;
         if (bus.ioctl_wait) saw_wait = 1;
      end
      chk("burst_accepted", 32'(i), 32'd8);
      bus.ioctl_wr = 0;
      bus.ioctl_download = 0;
      measure_fall(n_edges, n_pulses);
      chk("drain_pulses", 32'(n_pulses), 32'd3);
      chk("drain_hold_edges", 32'(n_edges), 32'd1031);
      chk("burst_saw_wait", 32'(saw_wait), 32'd1);
      chk("burst_ovf", 32'(ovf), 32'd0);
      chk("burst_count", 32'(got.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < got.size())
            chk($sformatf("burst_order_%0d", k), 32'(got[k]), 32'({17'(32'h100 + k), bdata[k]}));
      end

      // one-cycle ext_reset in RUN
      ext = 1;
      step();
      ext = 0;
      chk("ext_core_reset", 32'(core_reset), 32'd1);
      chk("ext_busy", 32'(busy), 32'd1);
      measure_fall(n_edges, n_pulses);
      chk("ext_hold_edges", 32'(n_edges), 32'd1024);

      // download rising mid-hold abandons the counter
      ext = 1;
      step();
      ext = 0;
      repeat (500) step();
      bus.ioctl_download = 1;
      repeat (600) step();
      chk("hold_abort_core_reset", 32'(core_reset), 32'd1);
      chk("hold_abort_busy", 32'(busy), 32'd1);
      ext = 1;
      step();
      ext = 0;
      repeat (3) step();
      chk("ext_ignored_in_load", 32'(busy), 32'd1);

      // overflow by ignoring wait, then reset mid-download
      for (int k = 0; k < 10; k++) begin
         bus.ioctl_wr = 1; bus.ioctl_addr = 25'(32'h200 + k); bus.ioctl_dout = 8'(k);
         step();
      end
      bus.ioctl_wr = 0;
      chk("ovf_set", 32'(ovf), 32'd1);
      rst = 1;
      step();
      rst = 0;
      bus.ioctl_download = 0;
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      repeat (10) step();
      chk("rst_no_writes", 32'(bus.dn_wr), 32'd0);

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_checks++;
      n_fail++;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
